// File: rtl/serial_nibble_collector.sv
// Assembles serial bits into WIDTH-bit words (MSB- or LSB-first, chosen per word)
// and queues completed words in a show-ahead FIFO with a sticky overflow flag.
module serial_nibble_collector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     msb_first,
    input  logic                     flush,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             order_q, order_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             cur_order;
    logic [WIDTH-1:0] shifted;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;

    always_comb begin
        accept = bit_valid && !flush;
        // The first bit of a word uses the live msb_first; later bits use the latched order.
        cur_order = (bit_cnt_q == '0) ? msb_first : order_q;
        shifted = cur_order ? {acc_q[WIDTH-2:0], bit_in} : {bit_in, acc_q[WIDTH-1:1]};
        push = accept && (bit_cnt_q == LAST_BIT);
        pop = (level_q != '0) && out_ready;
        full = (level_q == FULL_LVL);
        // When full, a coinciding pop frees the slot the push writes into.
        wr_en = push && (!full || pop);
        drop = push && full && !pop;
    end

    always_comb begin
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        order_d    = order_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush) begin
            acc_d     = '0;
            bit_cnt_d = '0;
        end else if (accept) begin
            acc_d     = shifted;
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
            if (bit_cnt_q == '0) begin
                order_d = msb_first;
            end
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LW'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            order_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            order_q    <= order_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while level is 0.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shifted;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign level     = level_q;
    assign bit_cnt   = bit_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_nibble_collector.sv
// Directed bench for serial_nibble_collector: assembly order, FIFO full/overflow,
// push/pop at full, flush and asynchronous reset.
module tb_serial_nibble_collector;

    logic       clock;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic       msb_first;
    logic       flush;
    logic       clr_ovf;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] level;
    logic [1:0] bit_cnt;
    logic       overflow;

    int tests_run;
    int tests_failed;

    serial_nibble_collector #(.WIDTH(4), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .msb_first (msb_first),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .bit_cnt   (bit_cnt),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clock);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic msb);
        msb_first = msb;
        for (int i = 0; i < 4; i++) begin
            send_bit(msb ? w[3-i] : w[i]);
        end
    endtask

    task automatic pop_word();
        $display("[TB] pop data=%h level=%0d", out_data, level);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (out_data !== 4'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        tests_run++;
        if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests_run++;
        if (bit_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_msb_first();
        msb_first = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        tests_run++;
        if (bit_cnt !== 2'd2) begin tests_failed++; $display("FAIL msb_bit_cnt: got %0d expected 2", bit_cnt); end
        send_bit(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL msb_early_valid: got %b expected 0", out_valid); end
        send_bit(1'b1);
        $display("[TB] msb word data=%h level=%0d", out_data, level);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL msb_out_valid: got %b expected 1", out_valid); end
        tests_run++;
        if (out_data !== 4'b1011) begin tests_failed++; $display("FAIL msb_out_data: got %b expected 1011", out_data); end
        tests_run++;
        if (level !== 3'd1) begin tests_failed++; $display("FAIL msb_level: got %0d expected 1", level); end
        tests_run++;
        if (bit_cnt !== 2'd0) begin tests_failed++; $display("FAIL msb_bit_cnt_wrap: got %0d expected 0", bit_cnt); end
        pop_word();
        tests_run++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++; $display("FAIL msb_pop_empty: got valid=%b level=%0d expected 0/0", out_valid, level);
        end
    endtask

    task automatic test_lsb_first();
        send_word(4'b1101, 1'b0);
        tests_run++;
        if (out_data !== 4'b1101) begin tests_failed++; $display("FAIL lsb_out_data: got %b expected 1101", out_data); end
        // Same bit sequence, msb_first flipped after the first bit must not matter.
        msb_first = 1'b0;
        send_bit(1'b1);
        msb_first = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tests_run++;
        if (level !== 3'd2) begin tests_failed++; $display("FAIL lsb_level: got %0d expected 2", level); end
        pop_word();
        tests_run++;
        if (out_data !== 4'b1101) begin tests_failed++; $display("FAIL lsb_toggle_data: got %b expected 1101", out_data); end
        pop_word();
        // out_ready while empty is a no-op.
        pop_word();
        tests_run++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL empty_pop: got level=%0d valid=%b expected 0/0", level, out_valid);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            send_word(4'(w), 1'b1);
        end
        tests_run++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            tests_failed++; $display("FAIL full_level: got level=%0d ovf=%b expected 4/0", level, overflow);
        end
        send_word(4'h5, 1'b1);
        tests_run++;
        if (level !== 3'd4) begin tests_failed++; $display("FAIL ovf_level: got %0d expected 4", level); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        // A drop coinciding with clr_ovf keeps overflow set.
        msb_first = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        clr_ovf = 1'b1;
        send_bit(1'b0);
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_clr_vs_drop: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        @(posedge clock);
        #1;
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int w = 1; w <= 4; w++) begin
            tests_run++;
            if (out_data !== 4'(w)) begin tests_failed++; $display("FAIL ovf_drain_%0d: got %h expected %h", w, out_data, 4'(w)); end
            pop_word();
        end
        tests_run++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++; $display("FAIL ovf_drained: got valid=%b level=%0d expected 0/0", out_valid, level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] w;
        for (int i = 0; i < 4; i++) begin
            send_word(4'hA + 4'(i), 1'b1);
        end
        tests_run++;
        if (level !== 3'd4) begin tests_failed++; $display("FAIL pp_fill: got %0d expected 4", level); end
        w = 4'hE;
        msb_first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            send_bit(w[3-i]);
        end
        out_ready = 1'b0;
        tests_run++;
        if (level !== 3'd4) begin tests_failed++; $display("FAIL pp_level: got %0d expected 4", level); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_data !== 4'hB + 4'(i)) begin
                tests_failed++; $display("FAIL pp_drain_%0d: got %h expected %h", i, out_data, 4'hB + 4'(i));
            end
            pop_word();
        end
    endtask

    task automatic test_flush();
        send_word(4'h6, 1'b1);
        msb_first = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        tests_run++;
        if (bit_cnt !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_cnt: got %0d expected 2", bit_cnt); end
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        tests_run++;
        if (bit_cnt !== 2'd0) begin tests_failed++; $display("FAIL flush_cnt: got %0d expected 0", bit_cnt); end
        tests_run++;
        if (level !== 3'd1 || out_data !== 4'h6) begin
            tests_failed++; $display("FAIL flush_fifo: got level=%0d data=%h expected 1/6", level, out_data);
        end
        send_word(4'h9, 1'b1);
        tests_run++;
        if (level !== 3'd2) begin tests_failed++; $display("FAIL flush_next_level: got %0d expected 2", level); end
        pop_word();
        tests_run++;
        if (out_data !== 4'h9) begin tests_failed++; $display("FAIL flush_next_word: got %h expected 9", out_data); end
        pop_word();
    endtask

    task automatic test_async_reset();
        send_word(4'h1, 1'b1);
        send_word(4'h2, 1'b1);
        send_word(4'h3, 1'b1);
        msb_first = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        tests_run++;
        if (level !== 3'd3 || bit_cnt !== 2'd2) begin
            tests_failed++; $display("FAIL ar_setup: got level=%0d cnt=%0d expected 3/2", level, bit_cnt);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || level !== 3'd0 || bit_cnt !== 2'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ar_immediate: got valid=%b data=%h level=%0d cnt=%0d ovf=%b expected all 0",
                     out_valid, out_data, level, bit_cnt, overflow);
        end
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        send_word(4'hC, 1'b1);
        tests_run++;
        if (level !== 3'd1 || out_data !== 4'hC) begin
            tests_failed++; $display("FAIL ar_resume: got level=%0d data=%h expected 1/c", level, out_data);
        end
        pop_word();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        msb_first    = 1'b1;
        flush        = 1'b0;
        clr_ovf      = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
